// File: rtl/note_pkg.sv
// Shared definitions for the song player: note-word layout, octave codes,
// tone half-period table and the playback FSM state encoding.
package note_pkg;

  localparam int unsigned NOTE_W   = 7;
  localparam int unsigned OCT_W    = 2;
  localparam int unsigned HP_W     = 19;
  localparam int unsigned NOTE_LSB = 2;
  localparam int unsigned OCT_LSB  = 0;

  localparam logic [OCT_W-1:0] OCT_MID  = 2'b00;
  localparam logic [OCT_W-1:0] OCT_HIGH = 2'b01;
  localparam logic [OCT_W-1:0] OCT_LOW  = 2'b10;
  localparam logic [OCT_W-1:0] OCT_RSV  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REWIND,
    ST_REQ,
    ST_CHECK,
    ST_PLAY,
    ST_GAP,
    ST_DONE
  } state_e;

  // Half-period in clocks: CLK_HZ/(2*f), shifted for high/low octave.
  function automatic logic [HP_W-1:0] half_period(input int unsigned clk_hz,
                                                  input logic [NOTE_W-1:0] note,
                                                  input logic [OCT_W-1:0] oct);
    logic [HP_W-1:0] base;
    case (note)
      7'b0000001: base = HP_W'(clk_hz / 524);
      7'b0000010: base = HP_W'(clk_hz / 588);
      7'b0000100: base = HP_W'(clk_hz / 660);
      7'b0001000: base = HP_W'(clk_hz / 698);
      7'b0010000: base = HP_W'(clk_hz / 784);
      7'b0100000: base = HP_W'(clk_hz / 880);
      7'b1000000: base = HP_W'(clk_hz / 988);
      default:    base = '0;
    endcase
    case (oct)
      OCT_HIGH: half_period = base >> 1;
      OCT_LOW:  half_period = base << 1;
      default:  half_period = base;
    endcase
  endfunction

  function automatic logic [OCT_W-1:0] norm_octave(input logic [OCT_W-1:0] oct);
    norm_octave = (oct == OCT_RSV) ? OCT_MID : oct;
  endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave divider: toggles the buzzer every half-period of the selected note
// while enabled; counter and buzzer are held at zero otherwise.
module tone_gen
  import note_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_en,
  input  logic [NOTE_W-1:0] i_note,
  input  logic [OCT_W-1:0]  i_octave,
  output logic              o_buzzer
);

  logic [HP_W-1:0] r_cnt;
  logic            r_buzzer;
  logic [HP_W-1:0] w_half;
  logic [HP_W-1:0] w_reload;
  logic            w_active;

  assign w_half   = half_period(CLK_HZ, i_note, i_octave);
  // Tiny half-periods saturate to toggling every clock.
  assign w_reload = (w_half > HP_W'(1)) ? (w_half - HP_W'(1)) : '0;
  assign w_active = i_en && $onehot(i_note);

  always_ff @(posedge clk) begin
    if (!rst_n || !w_active) begin
      r_cnt    <= '0;
      r_buzzer <= 1'b0;
    end else if (r_cnt == '0) begin
      r_cnt    <= w_reload;
      r_buzzer <= ~r_buzzer;
    end else begin
      r_cnt <= r_cnt - HP_W'(1);
    end
  end

  assign o_buzzer = r_buzzer;

endmodule

// File: rtl/song_player.sv
// Note-memory consumer: rewinds the memory, fetches one note word at a time,
// sounds each note for NOTE_CYCLES then stays silent for GAP_CYCLES.
module song_player
  import note_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned NOTE_CYCLES = 50_000_000,
  parameter int unsigned GAP_CYCLES  = 5_000_000,
  parameter int unsigned DATA_WIDTH  = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic                  mem_ready,
  output logic                  mem_read_en,
  output logic                  mem_read_rst,
  output logic                  buzzer,
  output logic [NOTE_W-1:0]     note_led,
  output logic [OCT_W-1:0]      octave,
  output logic                  playing,
  output logic                  done
);

  localparam int unsigned CNT_MAX = (NOTE_CYCLES > GAP_CYCLES) ? NOTE_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] NOTE_LOAD = CNT_W'(NOTE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
  localparam bit HAS_GAP = (GAP_CYCLES != 0);

  state_e            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [NOTE_W-1:0] r_note, w_note_nxt;
  logic [OCT_W-1:0]  r_oct, w_oct_nxt;
  logic              r_read_en, r_read_rst, r_playing, r_done;
  logic              w_tone_en;
  logic [NOTE_W-1:0] w_note_field;
  logic              w_note_ok;
  logic              w_unused_rsvd;

  assign w_note_field  = mem_data[NOTE_LSB +: NOTE_W];
  assign w_note_ok     = $onehot(w_note_field);
  assign w_unused_rsvd = ^mem_data[DATA_WIDTH-1:NOTE_LSB+NOTE_W];

  // Next-state, duration counter and latched note; rests latch as all-zero.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_note_nxt  = '0;
    w_oct_nxt   = '0;
    case (r_state)
      ST_IDLE:   if (start) w_state_nxt = ST_REWIND;
      ST_REWIND: w_state_nxt = ST_REQ;
      ST_REQ:    w_state_nxt = ST_CHECK;
      ST_CHECK: begin
        if (mem_ready) begin
          w_state_nxt = ST_PLAY;
          w_cnt_nxt   = NOTE_LOAD;
          if (w_note_ok) begin
            w_note_nxt = w_note_field;
            w_oct_nxt  = norm_octave(mem_data[OCT_LSB +: OCT_W]);
          end
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_PLAY: begin
        if (r_cnt == '0) begin
          if (HAS_GAP) begin
            w_state_nxt = ST_GAP;
            w_cnt_nxt   = GAP_LOAD;
          end else begin
            w_state_nxt = ST_REQ;
          end
        end else begin
          w_cnt_nxt  = r_cnt - CNT_W'(1);
          w_note_nxt = r_note;
          w_oct_nxt  = r_oct;
        end
      end
      ST_GAP: begin
        if (r_cnt == '0) w_state_nxt = ST_REQ;
        else             w_cnt_nxt   = r_cnt - CNT_W'(1);
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    if (stop && (r_state != ST_IDLE)) begin
      w_state_nxt = ST_IDLE;
      w_note_nxt  = '0;
      w_oct_nxt   = '0;
    end
    w_tone_en = (r_state == ST_PLAY) && (w_state_nxt == ST_PLAY);
  end

  // State register with outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_note     <= '0;
      r_oct      <= '0;
      r_read_en  <= 1'b0;
      r_read_rst <= 1'b0;
      r_playing  <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_note     <= w_note_nxt;
      r_oct      <= w_oct_nxt;
      r_read_en  <= (w_state_nxt == ST_REQ);
      r_read_rst <= (w_state_nxt == ST_REWIND);
      r_playing  <= w_state_nxt inside {ST_REWIND, ST_REQ, ST_CHECK, ST_PLAY, ST_GAP};
      r_done     <= (w_state_nxt == ST_DONE);
    end
  end

  tone_gen #(
    .CLK_HZ(CLK_HZ)
  ) u_tone_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_en     (w_tone_en),
    .i_note   (r_note),
    .i_octave (r_oct),
    .o_buzzer (buzzer)
  );

  assign mem_read_en  = r_read_en;
  assign mem_read_rst = r_read_rst;
  assign note_led     = r_note;
  assign octave       = r_oct;
  assign playing      = r_playing;
  assign done         = r_done;

endmodule

// File: tb/tb_song_player.sv
// Bench for song_player: behavioural note memory feeding a scoreboard of expected
// notes, a per-cycle monitor, and directed sequences for stop/reset/empty song.
module tb_song_player;

  localparam int unsigned CLK_HZ      = 2_620;
  localparam int unsigned NOTE_CYCLES = 20;
  localparam int unsigned GAP_CYCLES  = 4;
  localparam int          PERIOD      = NOTE_CYCLES + GAP_CYCLES + 2;

  logic       clk = 1'b0;
  logic       rst_n, start, stop;
  logic [9:0] mem_data  = '0;
  logic       mem_ready = 1'b0;
  logic       mem_read_en, mem_read_rst, buzzer, playing, done;
  logic [6:0] note_led;
  logic [1:0] octave;

  always #5 clk = ~clk;

  song_player #(
    .CLK_HZ(CLK_HZ), .NOTE_CYCLES(NOTE_CYCLES), .GAP_CYCLES(GAP_CYCLES), .DATA_WIDTH(10)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .mem_data(mem_data), .mem_ready(mem_ready),
    .mem_read_en(mem_read_en), .mem_read_rst(mem_read_rst), .buzzer(buzzer),
    .note_led(note_led), .octave(octave), .playing(playing), .done(done)
  );

  // Song entry: memory word plus what the player must show for it (hp=0 means silent).
  typedef struct {
    logic [9:0] word;
    logic [6:0] led;
    logic [1:0] oct;
    int         hp;
    bit         last;
  } note_t;

  note_t song[$];
  note_t sb[$];
  note_t cur;
  int    n_chk = 0, n_err = 0;
  int    ptr = 0;
  int    cyc = 0, ph = -1, p;
  int    done_cnt = 0, rst_cnt = 0, play_cnt = 0, buz_cnt = 0;
  int    en_cyc[$];
  bit    mon_clear = 1'b0;

  function automatic note_t mk(input logic [9:0] w, input logic [6:0] l,
                               input logic [1:0] o, input int h, input bit e);
    note_t n;
    n.word = w; n.led = l; n.oct = o; n.hp = h; n.last = e;
    return n;
  endfunction

  function automatic int outs();
    return int'({buzzer, note_led, octave, playing, done, mem_read_en, mem_read_rst});
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_req(input int target, input int max);
    for (int i = 0; i < max && en_cyc.size() < target; i++) step();
    chk("wait_req", int'(en_cyc.size() >= target), 1);
  endtask

  task automatic wait_done(input int base, input int max);
    for (int i = 0; i < max && done_cnt == base; i++) step();
    chk("wait_done", int'(done_cnt > base), 1);
  endtask

  // Note memory: serves a word per read_en, rewinds on read_rst; every fetch queues its expectation.
  always @(posedge clk) begin
    if (mem_read_rst === 1'b1) begin
      ptr       <= 0;
      mem_ready <= 1'b0;
    end else if (mem_read_en === 1'b1) begin
      if (ptr < song.size()) begin
        mem_data  <= song[ptr].word;
        mem_ready <= 1'b1;
        sb.push_back(song[ptr]);
        ptr <= ptr + 1;
      end else begin
        mem_ready <= 1'b0;
        sb.push_back(mk(10'h000, 7'h00, 2'b00, 0, 1'b1));
      end
    end
  end

  // Monitor: after each fetch request, CHECK is quiet, then PLAY/GAP or a done pulse.
  always @(negedge clk) begin
    cyc++;
    if (done === 1'b1)         done_cnt++;
    if (mem_read_rst === 1'b1) rst_cnt++;
    if (playing === 1'b1)      play_cnt++;
    if (buzzer === 1'b1)       buz_cnt++;
    if (mem_read_en === 1'b1)  en_cyc.push_back(cyc);
    if (mon_clear) begin
      ph = -1;
      sb.delete();
      mon_clear = 1'b0;
    end else if (ph < 0) begin
      if (mem_read_en === 1'b1) ph = 0;
    end else begin
      ph++;
      if (ph == 1) begin
        chk("check_quiet", int'({buzzer, note_led, octave}), 0);
        chk("sb_pending", int'(sb.size() != 0), 1);
        if (sb.size() == 0) ph = -1;
        else cur = sb.pop_front();
      end else if (cur.last) begin
        chk("end_done", int'(done), 1);
        chk("end_playing", int'(playing), 0);
        ph = -1;
      end else begin
        p = ph - 2;
        if (p < int'(NOTE_CYCLES)) begin
          chk("play_led", int'(note_led), int'(cur.led));
          chk("play_octave", int'(octave), int'(cur.oct));
          chk("play_buzzer", int'(buzzer),
              (cur.hp == 0 || p == 0) ? 0 : int'((((p - 1) / cur.hp) % 2) == 0));
          chk("play_playing", int'(playing), 1);
        end else if (p < int'(NOTE_CYCLES + GAP_CYCLES)) begin
          chk("gap_quiet", int'({buzzer, note_led, octave}), 0);
          chk("gap_playing", int'(playing), 1);
        end else begin
          chk("next_req", int'(mem_read_en), 1);
          ph = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int b_rst, b_done, b_en, b_play, b_buz;

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    step(3);
    chk("reset_outputs", outs(), 0);
    rst_n = 1'b1;
    step(2);
    chk("idle_outputs", outs(), 0);

    // do mid, sol mid, la high: half-periods 2620/524=5, 2620/784=3, (2620/880)>>1=1
    song.delete();
    song.push_back(mk(10'h004, 7'b0000001, 2'b00, 5, 1'b0));
    song.push_back(mk(10'h040, 7'b0010000, 2'b00, 3, 1'b0));
    song.push_back(mk(10'h081, 7'b0100000, 2'b01, 1, 1'b0));
    b_rst = rst_cnt; b_done = done_cnt; b_en = en_cyc.size();
    pulse_start();
    chk("t1_rewind", int'(mem_read_rst), 1);
    wait_req(b_en + 1, 10);
    step(10);
    pulse_start();
    wait_done(b_done, 200);
    chk("t1_rewind_once", rst_cnt - b_rst, 1);
    chk("t1_req_count", en_cyc.size() - b_en, 4);
    for (int k = 1; k < 4; k++)
      if (en_cyc.size() > b_en + k)
        chk("t1_req_spacing", en_cyc[b_en + k] - en_cyc[b_en + k - 1], PERIOD);
    step(3);
    chk("t1_done_once", done_cnt - b_done, 1);
    chk("t1_idle", outs(), 0);

    // Empty song
    song.delete();
    b_done = done_cnt; b_play = play_cnt; b_buz = buz_cnt;
    pulse_start();
    chk("t3_rewind", int'(mem_read_rst), 1);
    step(2);
    chk("t3_done_early", int'(done), 0);
    step();
    chk("t3_done_3clk", int'(done), 1);
    step();
    chk("t3_done_pulse", int'(done), 0);
    step(2);
    chk("t3_playing_cycles", play_cnt - b_play, 3);
    chk("t3_buzzer_silent", buz_cnt - b_buz, 0);
    chk("t3_done_once", done_cnt - b_done, 1);

    // Rest, two-hot rest, and do with reserved bit set and octave 11
    song.delete();
    song.push_back(mk(10'h000, 7'b0000000, 2'b00, 0, 1'b0));
    song.push_back(mk(10'h018, 7'b0000000, 2'b00, 0, 1'b0));
    song.push_back(mk(10'h207, 7'b0000001, 2'b00, 5, 1'b0));
    b_done = done_cnt; b_en = en_cyc.size();
    pulse_start();
    wait_done(b_done, 200);
    chk("t4_req_count", en_cyc.size() - b_en, 4);
    step(3);

    // Stop mid-PLAY of note 2 (start asserted too), then replay
    song.delete();
    song.push_back(mk(10'h004, 7'b0000001, 2'b00, 5, 1'b0));
    song.push_back(mk(10'h040, 7'b0010000, 2'b00, 3, 1'b0));
    song.push_back(mk(10'h081, 7'b0100000, 2'b01, 1, 1'b0));
    b_done = done_cnt; b_en = en_cyc.size();
    pulse_start();
    wait_req(b_en + 2, 100);
    step(6);
    chk("t5_in_play", int'(note_led), 7'b0010000);
    stop = 1'b1; start = 1'b1; mon_clear = 1'b1;
    step();
    stop = 1'b0; start = 1'b0;
    chk("t5_stop_outputs", outs(), 0);
    step(40);
    chk("t5_no_done", done_cnt - b_done, 0);
    chk("t5_still_idle", outs(), 0);
    chk("t5_no_fetch", en_cyc.size() - b_en, 2);
    b_rst = rst_cnt; b_done = done_cnt;
    pulse_start();
    chk("t5_replay_rewind", int'(mem_read_rst), 1);
    wait_done(b_done, 200);
    chk("t5_replay_rewind_once", rst_cnt - b_rst, 1);
    step(3);

    // Reset mid-GAP with start held
    b_rst = rst_cnt; b_en = en_cyc.size();
    pulse_start();
    wait_req(b_en + 1, 10);
    step(22);
    chk("t6_in_gap", int'({playing, note_led}), 128);
    rst_n = 1'b0; start = 1'b1; mon_clear = 1'b1;
    step();
    chk("t6_reset_outputs", outs(), 0);
    step();
    chk("t6_reset_hold", outs(), 0);
    rst_n = 1'b1; start = 1'b0;
    step(10);
    chk("t6_idle", outs(), 0);
    chk("t6_start_ignored", rst_cnt - b_rst, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
